metadata_insert_module: RTL



---
 rtl/metadata_insert_module_pkg.sv | 27 ++
 rtl/metadata_insert_module_byte_delay_line.sv | 41 ++++
 rtl/metadata_insert_module.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/metadata_insert_module_pkg.sv
// ---------------------------------------------------------------------------
// metadata_insert_module_pkg
// Shared definitions for the host-tx metadata insert stage and its host-rx
// counterpart (the strip/distinguish stage). Both sides must agree on the
// state encoding and on the metadata layout: a 19-bit control word in the
// top bits of a 64-bit word, followed by 45 zero bits.
// ---------------------------------------------------------------------------
package metadata_insert_module_pkg;

  localparam int META_BYTES  = 8;
  localparam int CTRL_W      = 19;
  localparam int META_ZERO_W = 45;
  localparam int META_W      = CTRL_W + META_ZERO_W;

  typedef enum logic [2:0] {
    IDLE_S  = 3'd0,
    META_S  = 3'd1,
    TRANS_S = 3'd2
  } pim_state_e;

  // Metadata goes out MSB first: byte 0 is meta[63:56], byte 7 is meta[7:0].
  function automatic logic [7:0] meta_byte(input logic [META_W-1:0] meta,
                                           input logic [2:0]        idx);
    return meta[META_W-1-8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/metadata_insert_module_byte_delay_line.sv
// ---------------------------------------------------------------------------
// byte_delay_line
// Fixed-depth shift register for {wr, 9-bit data} words. Shifts every cycle,
// including cycles where wr=0, so bubbles keep their position in the stream.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   in_wr, in_data  word entering stage 0
//   out_wr, out_data  word leaving the last stage
// ---------------------------------------------------------------------------
module byte_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       in_wr,
  input  logic [8:0] in_data,
  output logic       out_wr,
  output logic [8:0] out_data
);

  logic [DEPTH-1:0]      wr_q;
  logic [DEPTH-1:0][8:0] data_q;

  // Plain shift: stage 0 takes the input, every other stage takes its
  // neighbour. Reset clears valid bits and data so a partly delivered packet
  // cannot leak out after reset is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= {wr_q[DEPTH-2:0], in_wr};
      data_q <= {data_q[DEPTH-2:0], in_data};
    end
  end

  assign out_wr   = wr_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/metadata_insert_module.sv
// ---------------------------------------------------------------------------
// metadata_insert_module
// Host-transmit metadata insertion. Prepends 8 metadata bytes ({ctrl, 45'b0},
// MSB first) to each accepted packet. The payload is held back in a delay
// line while the metadata is emitted, then forwarded unchanged except that
// the head marker is cleared (on output the marker flags metadata byte 0
// and the packet tail). Heads that arrive while the output side is still
// busy are dropped and counted.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   iv_data          [8]=head/tail marker, [7:0]=byte
//   i_data_wr        input byte valid
//   iv_ctrl_data     19-bit control word, sampled on the head byte
//   ov_data          [8]=meta byte 0 / packet tail marker, [7:0]=byte
//   o_data_wr        output byte valid
//   o_drop_pulse     one-cycle pulse per dropped packet
//   ov_drop_cnt      saturating dropped-packet count
//   pim_state        FSM state, for debug
// ---------------------------------------------------------------------------
module metadata_insert_module #(
  parameter int META_BYTES = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [8:0]            iv_data,
  input  logic                  i_data_wr,
  input  logic [18:0]           iv_ctrl_data,
  output logic [8:0]            ov_data,
  output logic                  o_data_wr,
  output logic                  o_drop_pulse,
  output logic [DROP_CNT_W-1:0] ov_drop_cnt,
  output logic [2:0]            pim_state
);

  import metadata_insert_module_pkg::*;

  pim_state_e          state;
  pim_state_e          next_state;
  logic [2:0]          meta_cnt;
  logic [2:0]          next_meta_cnt;
  logic [META_W-1:0]   rv_meta;
  logic                r_in_busy;
  logic                r_in_disc;
  logic                r_entry_wr;
  logic [8:0]          r_entry_data;
  logic                dl_out_wr;
  logic [8:0]          dl_out_data;
  logic                head_seen;
  logic                tail_out;
  logic                fsm_free;
  logic                head_ok;
  logic                head_drop;
  logic                busy_byte;

  // A marked byte is a head only when no packet (accepted or discarded) is
  // open on the input side; otherwise the marker is that packet's tail.
  assign head_seen = i_data_wr & iv_data[8] & ~r_in_busy & ~r_in_disc;

  // The output side can take a new packet when idle, or on the very cycle
  // the previous tail leaves. Allowing the latter is what makes an 8-cycle
  // input gap sustainable: the old tail and the new metadata byte 0 come
  // out back to back.
  assign tail_out  = (state == TRANS_S) & dl_out_wr & dl_out_data[8];
  assign fsm_free  = (state == IDLE_S) | tail_out;
  assign head_ok   = head_seen & fsm_free;
  assign head_drop = head_seen & ~fsm_free;
  assign busy_byte = r_in_busy & i_data_wr;

  // Input-side packet flags. r_in_busy covers an accepted packet, r_in_disc
  // a dropped one; both close on the next marked byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_busy <= 1'b0;
      r_in_disc <= 1'b0;
    end else begin
      if (head_ok)
        r_in_busy <= 1'b1;
      else if (busy_byte && iv_data[8])
        r_in_busy <= 1'b0;

      if (head_drop)
        r_in_disc <= 1'b1;
      else if (r_in_disc && i_data_wr && iv_data[8])
        r_in_disc <= 1'b0;
    end
  end

  // Entry register in front of the delay line. Together with the 8 delay
  // stages it places payload byte k exactly one cycle after the last
  // metadata byte. The head byte enters with its marker cleared so that on
  // output only the real tail is marked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry_wr   <= 1'b0;
      r_entry_data <= '0;
    end else begin
      r_entry_wr <= head_ok | busy_byte;
      if (head_ok)
        r_entry_data <= {1'b0, iv_data[7:0]};
      else if (busy_byte)
        r_entry_data <= iv_data;
      else
        r_entry_data <= '0;
    end
  end

  // Metadata word is captured once per accepted packet and held while the
  // FSM walks through its bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      rv_meta <= '0;
    else if (head_ok)
      rv_meta <= {iv_ctrl_data, {META_ZERO_W{1'b0}}};
  end

  // Drop reporting: a pulse per dropped head and a counter that sticks at
  // all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_pulse <= 1'b0;
      ov_drop_cnt  <= '0;
    end else begin
      o_drop_pulse <= head_drop;
      if (head_drop && (ov_drop_cnt != {DROP_CNT_W{1'b1}}))
        ov_drop_cnt <= ov_drop_cnt + DROP_CNT_W'(1);
    end
  end

  byte_delay_line #(
    .DEPTH (META_BYTES)
  ) u_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .in_wr    (r_entry_wr),
    .in_data  (r_entry_data),
    .out_wr   (dl_out_wr),
    .out_data (dl_out_data)
  );

  // FSM state register, with the metadata byte index alongside it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE_S;
      meta_cnt <= '0;
    end else begin
      state    <= next_state;
      meta_cnt <= next_meta_cnt;
    end
  end

  // Next-state logic: IDLE -> META for the 8 metadata bytes -> TRANS until
  // the tail has been emitted. A head accepted on the tail cycle goes
  // straight back to META.
  always_comb begin
    next_state    = state;
    next_meta_cnt = meta_cnt;
    case (state)
      IDLE_S: begin
        if (head_ok) begin
          next_state    = META_S;
          next_meta_cnt = '0;
        end
      end
      META_S: begin
        if (meta_cnt == 3'(META_BYTES - 1)) begin
          next_state    = TRANS_S;
          next_meta_cnt = '0;
        end else begin
          next_meta_cnt = meta_cnt + 3'd1;
        end
      end
      TRANS_S: begin
        if (tail_out) begin
          next_state    = head_ok ? META_S : IDLE_S;
          next_meta_cnt = '0;
        end
      end
      default: begin
        next_state    = IDLE_S;
        next_meta_cnt = '0;
      end
    endcase
  end

  // Output logic: metadata bytes come from the captured word, payload from
  // the last delay stage, nothing while idle.
  always_comb begin
    ov_data   = '0;
    o_data_wr = 1'b0;
    case (state)
      META_S: begin
        ov_data   = {(meta_cnt == 3'd0), meta_byte(rv_meta, meta_cnt)};
        o_data_wr = 1'b1;
      end
      TRANS_S: begin
        ov_data   = dl_out_data;
        o_data_wr = dl_out_wr;
      end
      default: begin
        ov_data   = '0;
        o_data_wr = 1'b0;
      end
    endcase
  end

  assign pim_state = state;

endmodule
